// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default geometry and the Gray/binary conversion helpers.
// The helpers work on 32-bit values; callers zero-extend and truncate to their pointer width.
package fifo_pkg;

    localparam int unsigned ADDRESS_SIZE_DEFAULT = 4;
    localparam int unsigned SYNC_STAGES_DEFAULT  = 2;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at and above it.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i + 1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/read_ctrl_gray_if.sv
// Read-side port bundle of the async FIFO controller.
// master: the consumer / storage side; slave: the read controller itself.
interface read_ctrl_gray_if
    import fifo_pkg::*;
#(
    parameter int unsigned ADDRESS_SIZE = ADDRESS_SIZE_DEFAULT
);
    logic                    read_incr;
    logic [ADDRESS_SIZE:0]   write_gray_a;
    logic [ADDRESS_SIZE:0]   ae_threshold;
    logic                    read_underflow_clr;
    logic [ADDRESS_SIZE:0]   read_gray;
    logic [ADDRESS_SIZE-1:0] read_address;
    logic                    read_empty;
    logic                    read_almost_empty;
    logic [ADDRESS_SIZE:0]   read_level;
    logic                    read_underflow;

    modport master (
        output read_incr, write_gray_a, ae_threshold, read_underflow_clr,
        input  read_gray, read_address, read_empty, read_almost_empty, read_level,
               read_underflow
    );

    modport slave (
        input  read_incr, write_gray_a, ae_threshold, read_underflow_clr,
        output read_gray, read_address, read_empty, read_almost_empty, read_level,
               read_underflow
    );

endinterface

// File: rtl/gray_sync.sv
// Multi-flop synchronizer for a Gray-coded pointer crossing into this clock domain.
module gray_sync
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH       = ADDRESS_SIZE_DEFAULT + 1,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] stage_q [SYNC_STAGES];

    // Shift the pointer through the flop chain; reset clears every stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_q[i - 1];
            end
        end
    end

    assign dout = stage_q[SYNC_STAGES - 1];

endmodule

// File: rtl/read_ctrl_gray.sv
// Read-side pointer/flag controller of an asynchronous FIFO.
// Optional sticky underflow flag enabled by defining READ_UNDERFLOW_FLAG_EN.
module read_ctrl_gray
    import fifo_pkg::*;
#(
    parameter int unsigned ADDRESS_SIZE = ADDRESS_SIZE_DEFAULT,
    parameter int unsigned SYNC_STAGES  = SYNC_STAGES_DEFAULT
) (
    input  logic            read_clk,
    input  logic            rreset,
    read_ctrl_gray_if.slave bus
);
    localparam int unsigned PW = ADDRESS_SIZE + 1;

    logic [PW-1:0] rbin_q, rbin_d;
    logic [PW-1:0] rgray_q, rgray_d;
    logic [PW-1:0] level_q, level_d;
    logic [PW-1:0] wgray_s, wbin_s;
    logic          empty_q, empty_d;
    logic          aempty_q, aempty_d;
    logic          accept;

    gray_sync #(
        .WIDTH       (PW),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_wsync (
        .clk  (read_clk),
        .rst  (rreset),
        .din  (bus.write_gray_a),
        .dout (wgray_s)
    );

    // Flags are computed from the next pointer so empty asserts on the popping edge itself.
    always_comb begin
        accept   = bus.read_incr & ~empty_q;
        rbin_d   = rbin_q + PW'(accept);
        rgray_d  = PW'(bin2gray(32'(rbin_d)));
        wbin_s   = PW'(gray2bin(32'(wgray_s)));
        empty_d  = (rgray_d == wgray_s);
        level_d  = wbin_s - rbin_d;
        aempty_d = (level_d <= bus.ae_threshold);
    end

    // Pointer and flag registers; reset presents an empty FIFO.
    always_ff @(posedge read_clk or posedge rreset) begin
        if (rreset) begin
            rbin_q   <= '0;
            rgray_q  <= '0;
            level_q  <= '0;
            empty_q  <= 1'b1;
            aempty_q <= 1'b1;
        end else begin
            rbin_q   <= rbin_d;
            rgray_q  <= rgray_d;
            level_q  <= level_d;
            empty_q  <= empty_d;
            aempty_q <= aempty_d;
        end
    end

    assign bus.read_gray         = rgray_q;
    assign bus.read_address      = rbin_q[ADDRESS_SIZE-1:0];
    assign bus.read_empty        = empty_q;
    assign bus.read_almost_empty = aempty_q;
    assign bus.read_level        = level_q;

`ifdef READ_UNDERFLOW_FLAG_EN
    logic underflow_q;

    // Sticky underflow: a new underflow wins over a clear on the same edge.
    always_ff @(posedge read_clk or posedge rreset) begin
        if (rreset) begin
            underflow_q <= 1'b0;
        end else if (bus.read_incr & empty_q) begin
            underflow_q <= 1'b1;
        end else if (bus.read_underflow_clr) begin
            underflow_q <= 1'b0;
        end
    end

    assign bus.read_underflow = underflow_q;
`else
    logic unused_underflow_clr;

    assign unused_underflow_clr = bus.read_underflow_clr;
    assign bus.read_underflow   = 1'b0;
`endif

endmodule

// File: tb/tb_read_ctrl_gray.sv
// Directed, table-driven bench for read_ctrl_gray (ADDRESS_SIZE=4, SYNC_STAGES=2).
module tb_read_ctrl_gray;

`ifdef READ_UNDERFLOW_FLAG_EN
    localparam bit UF_EN = 1'b1;
`else
    localparam bit UF_EN = 1'b0;
`endif

    logic clk;
    logic rreset;

    read_ctrl_gray_if #(.ADDRESS_SIZE(4)) bus ();

    read_ctrl_gray #(
        .ADDRESS_SIZE (4),
        .SYNC_STAGES  (2)
    ) dut (
        .read_clk (clk),
        .rreset   (rreset),
        .bus      (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic       incr;
        logic       clr;
        logic [4:0] wgray;
        logic [4:0] level;
        logic       empty;
        logic       ae;
        logic [3:0] addr;
        logic [4:0] rgray;
        logic       uf;
    } vec_t;

    vec_t vecs [17];
    int   checks;
    int   errors;

    function automatic logic [4:0] g5(input int unsigned v);
        logic [4:0] b;
        b = 5'(v);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input int idx, input int unsigned act,
                       input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int idx, input vec_t v);
        chk({tag, "_level"}, idx, 32'(bus.read_level), 32'(v.level));
        chk({tag, "_empty"}, idx, 32'(bus.read_empty), 32'(v.empty));
        chk({tag, "_aempty"}, idx, 32'(bus.read_almost_empty), 32'(v.ae));
        chk({tag, "_addr"}, idx, 32'(bus.read_address), 32'(v.addr));
        chk({tag, "_rgray"}, idx, 32'(bus.read_gray), 32'(v.rgray));
        chk({tag, "_uf"}, idx, 32'(bus.read_underflow), 32'(v.uf));
    endtask

    initial begin
        vec_t        v;
        logic [4:0]  prev_gray;
        int unsigned ptr;
        int unsigned w0;

        checks = 0;
        errors = 0;

        //            incr  clr   wgray     lvl    emp   ae    addr   rgray     uf
        vecs[0]  = '{1'b0, 1'b0, 5'b00010, 5'd0, 1'b1, 1'b1, 4'd0, 5'b00000, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 5'b00010, 5'd0, 1'b1, 1'b1, 4'd0, 5'b00000, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 5'b00010, 5'd3, 1'b0, 1'b0, 4'd0, 5'b00000, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 5'b00010, 5'd2, 1'b0, 1'b1, 4'd1, 5'b00001, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 5'b00010, 5'd1, 1'b0, 1'b1, 4'd2, 5'b00011, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 5'b00010, 5'd0, 1'b1, 1'b1, 4'd3, 5'b00010, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 5'b00010, 5'd0, 1'b1, 1'b1, 4'd3, 5'b00010, UF_EN};
        vecs[7]  = '{1'b1, 1'b1, 5'b00010, 5'd0, 1'b1, 1'b1, 4'd3, 5'b00010, UF_EN};
        vecs[8]  = '{1'b0, 1'b1, 5'b00010, 5'd0, 1'b1, 1'b1, 4'd3, 5'b00010, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 5'b00111, 5'd0, 1'b1, 1'b1, 4'd3, 5'b00010, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 5'b00111, 5'd0, 1'b1, 1'b1, 4'd3, 5'b00010, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 5'b00111, 5'd2, 1'b0, 1'b1, 4'd3, 5'b00010, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 5'b00101, 5'd2, 1'b0, 1'b1, 4'd3, 5'b00010, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 5'b00101, 5'd2, 1'b0, 1'b1, 4'd3, 5'b00010, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 5'b00101, 5'd2, 1'b0, 1'b1, 4'd4, 5'b00110, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 5'b00101, 5'd1, 1'b0, 1'b1, 4'd5, 5'b00111, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 5'b00101, 5'd0, 1'b1, 1'b1, 4'd6, 5'b00101, 1'b0};

        rreset                 = 1'b1;
        bus.read_incr          = 1'b0;
        bus.read_underflow_clr = 1'b0;
        bus.write_gray_a       = '0;
        bus.ae_threshold       = 5'd2;

        // Reset state, before any clock edge.
        #2;
        v = '{1'b0, 1'b0, 5'b0, 5'd0, 1'b1, 1'b1, 4'd0, 5'b0, 1'b0};
        chk_all("reset", 0, v);
        step();
        step();
        rreset = 1'b0;

        // Fill, drain, underflow, simultaneous pop/advance.
        for (int i = 0; i < 17; i++) begin
            bus.read_incr          = vecs[i].incr;
            bus.read_underflow_clr = vecs[i].clr;
            bus.write_gray_a       = vecs[i].wgray;
            step();
            chk_all("vec", i, vecs[i]);
        end
        bus.read_incr          = 1'b0;
        bus.read_underflow_clr = 1'b0;

        // Bring level to 5 (write binary 11, read pointer 6), then reset between edges.
        bus.write_gray_a = g5(11);
        step();
        step();
        step();
        chk("pre_reset_level", 0, 32'(bus.read_level), 5);
        #2;
        rreset = 1'b1;
        #1;
        v = '{1'b0, 1'b0, 5'b0, 5'd0, 1'b1, 1'b1, 4'd0, 5'b0, 1'b0};
        chk_all("midreset", 0, v);
        bus.read_incr = 1'b1;
        step();
        rreset = 1'b0;

        // Pop held high across release: accepted only once empty has fallen.
        step();
        v = '{1'b1, 1'b0, 5'b0, 5'd0, 1'b1, 1'b1, 4'd0, 5'b0, UF_EN};
        chk_all("release", 1, v);
        step();
        chk_all("release", 2, v);
        step();
        v = '{1'b1, 1'b0, 5'b0, 5'd11, 1'b0, 1'b0, 4'd0, 5'b0, UF_EN};
        chk_all("release", 3, v);
        step();
        v = '{1'b1, 1'b0, 5'b0, 5'd10, 1'b0, 1'b0, 4'd1, 5'b00001, UF_EN};
        chk_all("release", 4, v);
        bus.read_incr          = 1'b0;
        bus.read_underflow_clr = 1'b1;
        step();
        chk("uf_clear", 0, 32'(bus.read_underflow), 0);
        bus.read_underflow_clr = 1'b0;

        // Streaming: write kept 16 ahead in the synchronized view, pointer wraps 31 -> 0.
        ptr = 1;
        w0  = ptr + 16;
        bus.write_gray_a = g5(w0);
        step();
        step();
        step();
        chk("full_level", 0, 32'(bus.read_level), 16);
        bus.write_gray_a = g5(w0 + 1);
        step();
        chk("prime_level", 1, 32'(bus.read_level), 16);
        bus.write_gray_a = g5(w0 + 2);
        step();
        chk("prime_level", 2, 32'(bus.read_level), 16);
        prev_gray = bus.read_gray;
        chk("prime_gray", 0, 32'(prev_gray), 32'(g5(ptr)));
        for (int k = 1; k <= 40; k++) begin
            bus.read_incr    = 1'b1;
            bus.write_gray_a = g5(w0 + 32'(k) + 2);
            step();
            ptr = (ptr + 1) % 32;
            chk("stream_level", k, 32'(bus.read_level), 16);
            chk("stream_empty", k, 32'(bus.read_empty), 0);
            chk("stream_aempty", k, 32'(bus.read_almost_empty), 0);
            chk("stream_addr", k, 32'(bus.read_address), ptr % 16);
            chk("stream_gray", k, 32'(bus.read_gray), 32'(g5(ptr)));
            chk("stream_gray_step", k, 32'($countones(bus.read_gray ^ prev_gray)), 1);
            prev_gray = bus.read_gray;
        end
        bus.read_incr = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/read_ctrl_gray.md
READ_CTRL_GRAY -- requirements
Module: read_ctrl_gray

Interface
REQ-001 Parameter ADDRESS_SIZE, default 4; storage depth is 2**ADDRESS_SIZE, pointer width is ADDRESS_SIZE+1.
REQ-002 Parameter SYNC_STAGES, default 2, legal range 2..4; flop count of the write-pointer synchronizer.
REQ-003 read_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rreset  input  1  reset, asynchronous assert, active-high.
REQ-005 read_incr  input  1  pop request.
REQ-006 write_gray_a  input  ADDRESS_SIZE+1  Gray-coded write pointer, asynchronous to read_clk.
REQ-007 ae_threshold  input  ADDRESS_SIZE+1  almost-empty level threshold, quasi-static.
REQ-008 read_gray  output  ADDRESS_SIZE+1  registered Gray-coded read pointer, for the write domain.
REQ-009 read_address  output  ADDRESS_SIZE  storage read address, equal to the low ADDRESS_SIZE bits of the binary read pointer.
REQ-010 read_empty  output  1  registered empty flag.
REQ-011 read_almost_empty  output  1  registered, level <= ae_threshold.
REQ-012 read_level  output  ADDRESS_SIZE+1  registered occupancy, range 0..2**ADDRESS_SIZE.
REQ-013 read_underflow  output  1  sticky underflow flag (see REQ-026).
REQ-014 read_underflow_clr  input  1  clears read_underflow.

Function
REQ-015 Pop accepted = read_incr & ~read_empty; a pop request while read_empty=1 SHALL be ignored.
REQ-016 Binary pointer next = pointer + accepted, modulo 2**(ADDRESS_SIZE+1); the pointer wraps from all-ones to 0 with no special case.
REQ-017 read_gray SHALL register next ^ (next >> 1); consecutive values SHALL differ in at most one bit.
REQ-018 write_gray_a SHALL pass through SYNC_STAGES flops, then be converted Gray-to-binary (wbin_s).
REQ-019 read_empty SHALL register (Gray of next pointer == synchronized write Gray); it falls SYNC_STAGES+1 edges after write_gray_a changes.
REQ-020 read_empty SHALL assert on the same edge that the last entry is popped; no extra latency.
REQ-021 read_level SHALL register (wbin_s - next) modulo 2**(ADDRESS_SIZE+1).
REQ-022 read_almost_empty SHALL register (that level <= ae_threshold); with ae_threshold=0 it equals read_empty.
REQ-023 A simultaneous pop and write-pointer advance SHALL leave read_level unchanged and keep read_empty=0.

Reset
REQ-024 While rreset=1: binary pointer, read_gray, read_address, synchronizer flops and read_level = 0; read_empty = 1; read_almost_empty = 1; read_underflow = 0.
REQ-025 Reset asserted mid-operation SHALL take effect without a clock edge; the first pop is accepted no earlier than the first edge after release on which read_empty=0.

Configuration
REQ-026 Macro READ_UNDERFLOW_FLAG_EN: when defined, read_underflow sets on any edge with read_incr & read_empty and holds until an edge with read_underflow_clr=1 and no new underflow; a set and a clear on the same edge leave it set.
REQ-027 When READ_UNDERFLOW_FLAG_EN is undefined, read_underflow SHALL be constant 0 and read_underflow_clr SHALL be ignored; no flop is inferred for it.

Structure
REQ-028 Shared package fifo_pkg SHALL hold the bin2gray/gray2bin functions and the ADDRESS_SIZE/SYNC_STAGES defaults.
REQ-029 Sub-module gray_sync (parameters WIDTH, SYNC_STAGES; reset as REQ-004) SHALL implement the synchronizer flop chain.

Verification (ADDRESS_SIZE=4, SYNC_STAGES=2, ae_threshold=2)
REQ-030 Reset pulse mid-stream, with level=5 -> read_empty=1, read_level=0, read_gray=0 immediately, before any clock edge.
REQ-031 write_gray_a 0 -> 5'b00010 (binary 3) -> read_empty=0 and read_level=3 on the 3rd edge; read_almost_empty=0.
REQ-032 Three consecutive pops from level 3 -> level 2 (read_almost_empty=1), then 1, then 0; read_empty=1 on the third pop edge; read_address sequence 0,1,2.
REQ-033 40 push/pop cycles with write held 16 ahead -> read_level=16, read_empty=0, binary pointer wraps 31->0, every read_gray step differs in exactly one bit.
REQ-034 Pop while empty -> pointer holds and read_underflow=1; pop plus clr on the same edge -> stays 1; clr alone -> 0; with the macro undefined, read_underflow stays 0 throughout.
